// File: rtl/sram_like_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_like_if : initiator/responder side of the SRAM-like bus        |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
interface sram_like_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface
`default_nettype wire

// File: rtl/sram_like_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_like_responder : in-order SRAM-like bus target with a queued,  |
// | minimum-latency issue stage in front of a 1-cycle synchronous RAM.  |
// | Revision            : 1.0                                           |
// +--------------------------------------------------------------------+
module sram_like_responder #(
  parameter int RAM_AW      = 16,
  parameter int OUTSTANDING = 4,
  parameter int DATA_DELAY  = 2
) (
  input  logic                clk,
  input  logic                resetn,
  sram_like_responder_if.slave bus,
  output logic                ram_en,
  output logic [3:0]          ram_wen,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [31:0]         ram_wdata,
  input  logic [31:0]         ram_rdata
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int DLY_W = (DATA_DELAY > 1) ? $clog2(DATA_DELAY) : 1;
  localparam int BA_W  = RAM_AW + 2;
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(DATA_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);

  typedef struct packed {
    logic             wr;
    logic [1:0]       size;
    logic [BA_W-1:0]  addr;
    logic [31:0]      wdata;
    logic [DLY_W-1:0] dly;
  } entry_t;

  entry_t [OUTSTANDING-1:0] q_q, q_d;
  logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0] issue_ptr_q, issue_ptr_d;
  logic [PTR_W-1:0] resp_ptr_q, resp_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pend_q, pend_d;   // allocated but not yet issued
  logic             resp_pending_q, resp_pending_d;

  logic   push, issue, issue_mis, resp_mis;
  entry_t issue_e, resp_e;
  logic   addr_unused;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic m;
    case (sz)
      2'd0:    m = 1'b0;
      2'd1:    m = a[0];
      2'd2:    m = (a != 2'b00);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      2'd0:    be = 4'b0001 << a;
      2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  assign addr_unused = ^bus.addr[31:BA_W];

  assign bus.addr_ok = resetn && bus.req && (count_q < CNT_MAX);
  assign push        = bus.addr_ok;

  assign issue_e   = q_q[issue_ptr_q];
  assign resp_e    = q_q[resp_ptr_q];
  assign issue     = (pend_q != '0) && (issue_e.dly == '0);
  assign issue_mis = misaligned(issue_e.size, issue_e.addr[1:0]);
  assign resp_mis  = misaligned(resp_e.size, resp_e.addr[1:0]);

  // Misaligned requests consume an issue slot but never touch the RAM.
  assign ram_en    = issue && !issue_mis;
  assign ram_wen   = (ram_en && issue_e.wr) ? byte_en(issue_e.size, issue_e.addr[1:0]) : 4'b0000;
  assign ram_addr  = ram_en ? issue_e.addr[BA_W-1:2] : '0;
  assign ram_wdata = ram_en ? issue_e.wdata : '0;

  assign bus.data_ok = resp_pending_q;
  assign bus.rdata   = (resp_pending_q && !resp_e.wr && !resp_mis) ? ram_rdata : '0;

  always_comb begin
    q_d            = q_q;
    alloc_ptr_d    = alloc_ptr_q;
    issue_ptr_d    = issue_ptr_q;
    resp_ptr_d     = resp_ptr_q;
    count_d        = count_q;
    pend_d         = pend_q;
    resp_pending_d = issue;

    for (int i = 0; i < OUTSTANDING; i++) begin
      if (q_q[i].dly != '0) q_d[i].dly = q_q[i].dly - DLY_W'(1);
    end

    if (push) begin
      q_d[alloc_ptr_q] = '{wr: bus.wr, size: bus.size, addr: bus.addr[BA_W-1:0],
                           wdata: bus.wdata, dly: DLY_INIT};
      alloc_ptr_d = alloc_ptr_q + PTR_W'(1);
    end
    if (issue)       issue_ptr_d = issue_ptr_q + PTR_W'(1);
    if (bus.data_ok) resp_ptr_d  = resp_ptr_q + PTR_W'(1);

    case ({push, bus.data_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case ({push, issue})
      2'b10:   pend_d = pend_q + CNT_W'(1);
      2'b01:   pend_d = pend_q - CNT_W'(1);
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_q            <= '0;
      alloc_ptr_q    <= '0;
      issue_ptr_q    <= '0;
      resp_ptr_q     <= '0;
      count_q        <= '0;
      pend_q         <= '0;
      resp_pending_q <= 1'b0;
    end else begin
      q_q            <= q_d;
      alloc_ptr_q    <= alloc_ptr_d;
      issue_ptr_q    <= issue_ptr_d;
      resp_ptr_q     <= resp_ptr_d;
      count_q        <= count_d;
      pend_q         <= pend_d;
      resp_pending_q <= resp_pending_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_responder.sv
`default_nettype none
// Bench for sram_like_responder: three instances (DATA_DELAY 1/2/4) exercised one at a
// time against a transaction-level timing and memory model.
module tb_sram_like_responder;
  localparam int RAM_AW = 6;
  localparam int NW     = 1 << RAM_AW;
  localparam int NI     = 3;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NI-1:0]             resetn_a, req_a, wr_a, addr_ok_a, data_ok_a, ram_en_a;
  logic [NI-1:0][1:0]        size_a;
  logic [NI-1:0][31:0]       addr_a, wdata_a, rdata_a, ram_wdata_a;
  logic [NI-1:0][3:0]        ram_wen_a;
  logic [NI-1:0][RAM_AW-1:0] ram_addr_a;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int DD = (k == 0) ? 1 : (k == 1) ? 2 : 4;
    sram_like_responder_if bus ();
    logic [31:0] mem [NW];
    logic [31:0] ram_rdata;

    assign bus.req   = req_a[k];
    assign bus.wr    = wr_a[k];
    assign bus.size  = size_a[k];
    assign bus.addr  = addr_a[k];
    assign bus.wdata = wdata_a[k];
    assign addr_ok_a[k] = bus.addr_ok;
    assign data_ok_a[k] = bus.data_ok;
    assign rdata_a[k]   = bus.rdata;

    sram_like_responder #(.RAM_AW(RAM_AW), .OUTSTANDING(DEPTH), .DATA_DELAY(DD)) u_dut (
      .clk       (clk),
      .resetn    (resetn_a[k]),
      .bus       (bus),
      .ram_en    (ram_en_a[k]),
      .ram_wen   (ram_wen_a[k]),
      .ram_addr  (ram_addr_a[k]),
      .ram_wdata (ram_wdata_a[k]),
      .ram_rdata (ram_rdata)
    );

    always @(posedge clk) begin
      if (ram_en_a[k]) begin
        for (int b = 0; b < 4; b++)
          if (ram_wen_a[k][b]) mem[ram_addr_a[k]][8*b +: 8] <= ram_wdata_a[k][8*b +: 8];
        ram_rdata <= mem[ram_addr_a[k]];
      end
    end
  end

  typedef struct {
    int               issue_t;
    int               resp_t;
    logic             en;
    logic [3:0]       wen;
    logic [RAM_AW-1:0] waddr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
  } exp_t;

  exp_t        q[$];
  logic [31:0] shadow [NI][NW];
  int cur = 0, dd = 1, outstanding = 0, last_issue = -100;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (inst %0d, cycle %0d): observed %h expected %h", tag, cur, cyc, obs, exp);
    end
  endtask

  task automatic select(input int k);
    cur = k;
    dd = (k == 0) ? 1 : (k == 1) ? 2 : 4;
    outstanding = 0;
    last_issue = -100;
    q.delete();
  endtask

  // A request occupies bytes [a, a + 2^size) of its word; misaligned ones touch nothing.
  task automatic model_push();
    exp_t e;
    logic [31:0] a, d;
    logic [1:0]  s;
    logic        w, mis;
    logic [3:0]  be;
    int          widx, lo, n;
    a = addr_a[cur]; d = wdata_a[cur]; s = size_a[cur]; w = wr_a[cur];
    lo = int'(a[1:0]);
    n  = 1 << s;
    mis = (s == 2'd3) || ((lo % n) != 0);
    for (int b = 0; b < 4; b++) be[b] = (b >= lo) && (b < lo + n);
    widx = int'(a[RAM_AW+1:2]);
    e.issue_t = (cyc + dd > last_issue + 1) ? cyc + dd : last_issue + 1;
    last_issue = e.issue_t;
    e.resp_t = e.issue_t + 1;
    e.en    = !mis;
    e.wen   = (w && !mis) ? be : 4'b0000;
    e.waddr = a[RAM_AW+1:2];
    e.wdata = d;
    e.rdata = 32'h0;
    if (!mis) begin
      if (w) begin
        for (int b = 0; b < 4; b++) if (be[b]) shadow[cur][widx][8*b +: 8] = d[8*b +: 8];
      end else begin
        e.rdata = shadow[cur][widx];
      end
    end
    q.push_back(e);
    outstanding++;
  endtask

  task automatic tick(output bit acc);
    exp_t e;
    bit   hit, resp;
    logic exp_aok;
    @(negedge clk);
    exp_aok = req_a[cur] && (outstanding < DEPTH);
    chk("addr_ok", 32'(addr_ok_a[cur]), 32'(exp_aok));
    hit = 0;
    foreach (q[i]) if (q[i].issue_t == cyc) begin hit = 1; e = q[i]; end
    chk("ram_en", 32'(ram_en_a[cur]), hit ? 32'(e.en) : 32'h0);
    chk("ram_wen", 32'(ram_wen_a[cur]), hit ? 32'(e.wen) : 32'h0);
    if (hit && e.en) begin
      chk("ram_addr", 32'(ram_addr_a[cur]), 32'(e.waddr));
      chk("ram_wdata", ram_wdata_a[cur], e.wdata);
    end
    resp = (q.size() > 0) && (q[0].resp_t == cyc);
    chk("data_ok", 32'(data_ok_a[cur]), 32'(resp));
    chk("rdata", rdata_a[cur], resp ? q[0].rdata : 32'h0);
    if (resp) q.delete(0);
    acc = exp_aok;
    if (exp_aok) model_push();
    if (resp) outstanding--;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) tick(acc);
  endtask

  task automatic send(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    bit acc = 0;
    int n = 0;
    req_a[cur] = 1'b1; wr_a[cur] = w; size_a[cur] = s; addr_a[cur] = a; wdata_a[cur] = d;
    while (!acc && n < 40) begin tick(acc); n++; end
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL accept_timeout (inst %0d): observed no accept expected accept within 40 cycles", cur);
    end
    req_a[cur] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bit acc;
    while (q.size() > 0 && n < 60) begin tick(acc); n++; end
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout (inst %0d): observed %0d pending expected 0", cur, q.size());
    end
    tick(acc);
  endtask

  task automatic chk_zero(input int k);
    cur = k;
    chk("rst_addr_ok", 32'(addr_ok_a[k]), 32'h0);
    chk("rst_data_ok", 32'(data_ok_a[k]), 32'h0);
    chk("rst_rdata", rdata_a[k], 32'h0);
    chk("rst_ram_en", 32'(ram_en_a[k]), 32'h0);
    chk("rst_ram_wen", 32'(ram_wen_a[k]), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr_a[k]), 32'h0);
    chk("rst_ram_wdata", ram_wdata_a[k], 32'h0);
  endtask

  initial begin
    resetn_a = '0; req_a = '0; wr_a = '0; size_a = '0; addr_a = '0; wdata_a = '0;
    for (int k = 0; k < NI; k++) for (int w = 0; w < NW; w++) shadow[k][w] = 32'h0;
    req_a = '1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk_zero(k);
    req_a = '0;
    @(posedge clk); #1;
    resetn_a = '1;

    // DATA_DELAY = 2: directed word/byte/misaligned accesses, then random mix
    select(1);
    idle(2);
    send(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    send(1'b0, 2'd2, 32'h10, 32'h0);
    drain();
    send(1'b1, 2'd2, 32'h10, 32'h11223344);
    send(1'b1, 2'd0, 32'h13, 32'hAA000000);
    send(1'b0, 2'd2, 32'h10, 32'h0);
    drain();
    send(1'b0, 2'd2, 32'h22, 32'h0);
    send(1'b1, 2'd1, 32'h05, $urandom);
    send(1'b0, 2'd2, 32'h10, 32'h0);
    drain();
    for (int w = 0; w < 16; w++) send(1'b1, 2'd2, 32'(w * 4), $urandom);
    drain();
    for (int i = 0; i < 30; i++) begin
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)) | 32'hF000_0000, $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // DATA_DELAY = 4: held request stream saturates the queue, then reset mid-burst
    select(2);
    for (int w = 0; w < 6; w++) send(1'b1, 2'd2, 32'(w * 4), $urandom);
    drain();
    for (int w = 0; w < 6; w++) send(1'b0, 2'd2, 32'(w * 4), 32'h0);
    drain();
    for (int w = 0; w < 3; w++) send(1'b0, 2'd2, 32'(w * 4), 32'h0);
    req_a[cur] = 1'b1;
    resetn_a[cur] = 1'b0;
    q.delete(); outstanding = 0; last_issue = -100;
    repeat (3) begin
      @(negedge clk);
      chk_zero(2);
      @(posedge clk); #1;
    end
    req_a[cur] = 1'b0;
    resetn_a[cur] = 1'b1;
    idle(8);
    send(1'b0, 2'd2, 32'h4, 32'h0);
    drain();

    // DATA_DELAY = 1: back-to-back reads must stream one response per cycle
    select(0);
    for (int w = 0; w < 12; w++) send(1'b1, 2'd2, 32'(w * 4), $urandom);
    drain();
    for (int w = 0; w < 12; w++) send(1'b0, 2'd2, 32'(w * 4), 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed simulation still running expected finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
